// File: rtl/instr_fetch_decode_if.sv
// Signal bundle between the fetch/decode stage, its program memory and the MOV/ALU units.
// The master side is the fetch/decode stage; the slave side is memory plus execution units.
interface instr_fetch_decode_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  // Handshakes: pmRdEn is a one-cycle read request with no back-pressure; pmData is
  // valid exactly one cycle later. MOVstr/ALUstr are one-cycle start strobes. IF and
  // aluDone are one-cycle done pulses, accepted only while the matching unit runs and
  // silently dropped at any other time (never queued).
  logic [PC_W-1:0]    pmAddr;
  logic               pmRdEn;
  logic [INSTR_W-1:0] pmData;
  logic [3:0]         opCode;
  logic [3:0]         opI;
  logic [7:0]         opJ;
  logic               MOVstr;
  logic               ALUstr;
  logic               IF;
  logic               aluDone;
  logic               halted;
  logic               execErr;
  logic [2:0]         dbgState;

  modport master (
    output pmAddr, pmRdEn, opCode, opI, opJ, MOVstr, ALUstr, halted, execErr, dbgState,
    input  pmData, IF, aluDone
  );

  modport slave (
    input  pmAddr, pmRdEn, opCode, opI, opJ, MOVstr, ALUstr, halted, execErr, dbgState,
    output pmData, IF, aluDone
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Fetch/decode control stage of the MOV sequencer: fetches, decodes and launches MOV or ALU ops.
// Define IFD_TIMEOUT_EN to add an EXEC watchdog (TMO_CYC) that raises the sticky execErr flag.
module instr_fetch_decode #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
`ifdef IFD_TIMEOUT_EN
  ,
  parameter int TMO_CYC = 32
`endif
) (
  input logic                  clk,
  input logic                  reset,
  instr_fetch_decode_if.master bus
);

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_WAIT     = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC_MOV = 3'd3,
    ST_EXEC_ALU = 3'd4,
    ST_HALT     = 3'd5
  } ifdState_e;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_MOV_A = 4'b1001;
  localparam logic [3:0] OP_MOV_B = 4'b1010;
  localparam logic [3:0] OP_HLT   = 4'b1111;

  ifdState_e          state;
  ifdState_e          nextState;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         opCodeQ;
  logic [3:0]         opIQ;
  logic [7:0]         opJQ;
  logic               rdEnQ;
  logic               movStrQ;
  logic               aluStrQ;
  logic               haltedQ;
  logic               nextRdEn;
  logic               nextMovStr;
  logic               nextAluStr;
  logic               nextHalted;
  logic               tmoHit;
  logic [3:0]         irOp;
  logic [3:0]         memOp;

  assign irOp  = ir[INSTR_W-1 -: 4];
  assign memOp = bus.pmData[INSTR_W-1 -: 4];

  function automatic logic isMovOp(input logic [3:0] op);
    return (op == OP_MOV_A) || (op == OP_MOV_B);
  endfunction

  function automatic logic isAluOp(input logic [3:0] op);
    return !isMovOp(op) && (op != OP_NOP) && (op != OP_HLT);
  endfunction

  // State and registered Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_FETCH;
      rdEnQ   <= 1'b0;
      movStrQ <= 1'b0;
      aluStrQ <= 1'b0;
      haltedQ <= 1'b0;
    end else begin
      state   <= nextState;
      rdEnQ   <= nextRdEn;
      movStrQ <= nextMovStr;
      aluStrQ <= nextAluStr;
      haltedQ <= nextHalted;
    end
  end

  // Out of reset FETCH holds one cycle until the registered read enable is high,
  // so the first read is actually issued before moving on.
  always_comb begin
    nextState = state;
    unique case (state)
      ST_FETCH:    if (rdEnQ) nextState = ST_WAIT;
      ST_WAIT:     nextState = ST_DECODE;
      ST_DECODE: begin
        if (isMovOp(irOp))       nextState = ST_EXEC_MOV;
        else if (irOp == OP_NOP) nextState = ST_FETCH;
        else if (irOp == OP_HLT) nextState = ST_HALT;
        else                     nextState = ST_EXEC_ALU;
      end
      ST_EXEC_MOV: if (bus.IF || tmoHit)      nextState = ST_FETCH;
      ST_EXEC_ALU: if (bus.aluDone || tmoHit) nextState = ST_FETCH;
      ST_HALT:     nextState = ST_HALT;
      default:     nextState = ST_FETCH;
    endcase
  end

  // Strobes are precomputed from the word being latched into IR so they appear in DECODE.
  always_comb begin
    nextRdEn   = (nextState == ST_FETCH);
    nextMovStr = (state == ST_WAIT) && isMovOp(memOp);
    nextAluStr = (state == ST_WAIT) && isAluOp(memOp);
    nextHalted = (nextState == ST_HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      ir      <= '0;
      opCodeQ <= '0;
      opIQ    <= '0;
      opJQ    <= '0;
    end else begin
      if (state == ST_WAIT) ir <= bus.pmData;
      if (state == ST_DECODE) begin
        opCodeQ <= irOp;
        opIQ    <= ir[INSTR_W-5 -: 4];
        opJQ    <= ir[7:0];
        pc      <= pc + PC_W'(1);
      end
    end
  end

`ifdef IFD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmoCnt;
  logic             inExec;
  logic             doneNow;
  logic             execErrQ;

  assign inExec  = (state == ST_EXEC_MOV) || (state == ST_EXEC_ALU);
  assign doneNow = ((state == ST_EXEC_MOV) && bus.IF) || ((state == ST_EXEC_ALU) && bus.aluDone);
  assign tmoHit  = inExec && (tmoCnt == TMO_W'(TMO_CYC - 1));

  // tmoCnt holds (EXEC cycle index - 1); a done in the final cycle beats the timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmoCnt   <= '0;
      execErrQ <= 1'b0;
    end else begin
      if (state == ST_DECODE) tmoCnt <= '0;
      else if (inExec)        tmoCnt <= tmoCnt + TMO_W'(1);
      if (tmoHit && !doneNow) execErrQ <= 1'b1;
    end
  end

  assign bus.execErr = execErrQ;
`else
  assign tmoHit      = 1'b0;
  assign bus.execErr = 1'b0;
`endif

  assign bus.pmAddr   = pc;
  assign bus.pmRdEn   = rdEnQ;
  assign bus.opCode   = opCodeQ;
  assign bus.opI      = opIQ;
  assign bus.opJ      = opJQ;
  assign bus.MOVstr   = movStrQ;
  assign bus.ALUstr   = aluStrQ;
  assign bus.halted   = haltedQ;
  assign bus.dbgState = state;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: directed scenarios plus a random program checked
// against an instruction-level model of fetch order, launches and timing.
module tb_instr_fetch_decode;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] mem [256];
  logic [23:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_decode_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch_decode #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // synchronous program memory, one-cycle read latency
  always @(posedge clk) if (bus.pmRdEn) bus.pmData <= mem[bus.pmAddr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
  endtask

  task automatic wait_fetch(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      tick();
      if (bus.pmRdEn === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_prog(output bit ok);
    @(negedge clk);
    reset = 1'b0;
    bus.IF = 1'b0;
    bus.aluDone = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    wait_fetch(4, ok);
  endtask

  // Scenario: reset mid EXEC_MOV clears everything asynchronously, restart at address 0.
  task automatic test_reset();
    bit ok;
    clear_mem();
    mem[0] = 16'h9A35;
    start_prog(ok);
    n_cmp++; if (!ok || bus.pmAddr !== 8'h00) begin n_err++; $display("FAIL rst_first_fetch: ok=%0b addr=%h want fetch at 00", ok, bus.pmAddr); end
    tick(); tick(); tick();
    n_cmp++; if (bus.opCode !== 4'h9 || bus.pmAddr !== 8'h01) begin n_err++; $display("FAIL rst_pre_exec: opCode=%h addr=%h want 9/01", bus.opCode, bus.pmAddr); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({bus.pmAddr, bus.pmRdEn, bus.opCode, bus.opI, bus.opJ, bus.MOVstr, bus.ALUstr, bus.halted, bus.execErr} !== '0) begin
      n_err++; $display("FAIL rst_async: addr=%h rd=%b op=%h i=%h j=%h mov=%b alu=%b h=%b err=%b want all 0", bus.pmAddr, bus.pmRdEn, bus.opCode, bus.opI, bus.opJ, bus.MOVstr, bus.ALUstr, bus.halted, bus.execErr);
    end
    tick();
    reset = 1'b1;
    wait_fetch(4, ok);
    n_cmp++; if (!ok || bus.pmAddr !== 8'h00) begin n_err++; $display("FAIL rst_release: ok=%0b addr=%h want fetch at 00", ok, bus.pmAddr); end
  endtask

  // Scenario: MOV 9A35 with IF four cycles after the strobe.
  task automatic test_mov();
    bit ok;
    int mov_cnt = 0;
    int bad = 0;
    clear_mem();
    mem[0] = 16'h9A35;
    start_prog(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mov_start: no fetch got %0b want 1", ok); end
    tick();
    mov_cnt += int'(bus.MOVstr);
    tick();
    n_cmp++; if (bus.MOVstr !== 1'b1 || bus.ALUstr !== 1'b0) begin n_err++; $display("FAIL mov_strobe: mov=%b alu=%b want 1/0", bus.MOVstr, bus.ALUstr); end
    for (int j = 1; j <= 4; j++) begin
      tick();
      mov_cnt += int'(bus.MOVstr);
      if ({bus.opCode, bus.opI, bus.opJ} !== 16'h9A35 || bus.pmRdEn !== 1'b0) bad++;
      if (j == 4) bus.IF = 1'b1;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL mov_operands: %0d bad EXEC cycles want 0 (op=%h i=%h j=%h)", bad, bus.opCode, bus.opI, bus.opJ); end
    n_cmp++; if (mov_cnt != 0) begin n_err++; $display("FAIL mov_one_cycle: extra strobe cycles %0d want 0", mov_cnt); end
    tick();
    bus.IF = 1'b0;
    n_cmp++; if (bus.pmRdEn !== 1'b1 || bus.pmAddr !== 8'h01) begin n_err++; $display("FAIL mov_next_fetch: rd=%b addr=%h want 1/01", bus.pmRdEn, bus.pmAddr); end
  endtask

  // Scenario: NOP takes 3 cycles with no strobe, then ALU op 2107.
  task automatic test_nop_alu();
    bit ok;
    int strobes = 0;
    clear_mem();
    mem[1] = 16'h2107;
    start_prog(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL nop_start: no fetch got %0b want 1", ok); end
    tick();
    strobes += int'(bus.MOVstr) + int'(bus.ALUstr);
    tick();
    strobes += int'(bus.MOVstr) + int'(bus.ALUstr);
    tick();
    n_cmp++; if (strobes != 0) begin n_err++; $display("FAIL nop_no_strobe: got %0d strobes want 0", strobes); end
    n_cmp++; if (bus.pmRdEn !== 1'b1 || bus.pmAddr !== 8'h01) begin n_err++; $display("FAIL nop_period: rd=%b addr=%h want 1/01", bus.pmRdEn, bus.pmAddr); end
    tick();
    tick();
    n_cmp++; if (bus.ALUstr !== 1'b1 || bus.MOVstr !== 1'b0) begin n_err++; $display("FAIL alu_strobe: alu=%b mov=%b want 1/0", bus.ALUstr, bus.MOVstr); end
    tick();
    n_cmp++; if (bus.opCode !== 4'h2 || bus.opI !== 4'h1 || bus.opJ !== 8'h07 || bus.ALUstr !== 1'b0) begin n_err++; $display("FAIL alu_operands: op=%h i=%h j=%h alu=%b want 2/1/07/0", bus.opCode, bus.opI, bus.opJ, bus.ALUstr); end
    bus.IF = 1'b1;
    tick();
    bus.IF = 1'b0;
    n_cmp++; if (bus.pmRdEn !== 1'b0) begin n_err++; $display("FAIL alu_ignores_if: rd=%b want 0", bus.pmRdEn); end
    bus.aluDone = 1'b1;
    tick();
    bus.aluDone = 1'b0;
    n_cmp++; if (bus.pmRdEn !== 1'b1 || bus.pmAddr !== 8'h02) begin n_err++; $display("FAIL alu_done: rd=%b addr=%h want 1/02", bus.pmRdEn, bus.pmAddr); end
  endtask

  // Scenario: wrong-unit done ignored in EXEC, right-unit done outside EXEC not queued.
  task automatic test_ignore_done();
    bit ok;
    int bad = 0;
    clear_mem();
    mem[0] = 16'hA100;
    mem[1] = 16'hA2FF;
    start_prog(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ign_start: no fetch got %0b want 1", ok); end
    tick();
    tick();
    n_cmp++; if (bus.MOVstr !== 1'b1) begin n_err++; $display("FAIL ign_strobe: mov=%b want 1", bus.MOVstr); end
    tick();
    for (int j = 0; j < 6; j++) begin
      bus.aluDone = (j % 2 == 0);
      tick();
      if (bus.pmRdEn !== 1'b0 || bus.opCode !== 4'hA) bad++;
    end
    bus.aluDone = 1'b0;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL ign_alu_done: %0d cycles left EXEC_MOV want 0", bad); end
    bus.IF = 1'b1;
    tick();
    bus.IF = 1'b0;
    n_cmp++; if (bus.pmRdEn !== 1'b1 || bus.pmAddr !== 8'h01) begin n_err++; $display("FAIL ign_if_exit: rd=%b addr=%h want 1/01", bus.pmRdEn, bus.pmAddr); end
    bus.IF = 1'b1;
    tick();
    tick();
    tick();
    bus.IF = 1'b0;
    n_cmp++; if (bus.opI !== 4'h2 || bus.opJ !== 8'hFF || bus.pmRdEn !== 1'b0) begin n_err++; $display("FAIL ign_exec2: i=%h j=%h rd=%b want 2/FF/0", bus.opI, bus.opJ, bus.pmRdEn); end
    tick();
    n_cmp++; if (bus.pmRdEn !== 1'b0) begin n_err++; $display("FAIL ign_no_queue: rd=%b want 0", bus.pmRdEn); end
    bus.IF = 1'b1;
    tick();
    bus.IF = 1'b0;
    n_cmp++; if (bus.pmRdEn !== 1'b1 || bus.pmAddr !== 8'h02) begin n_err++; $display("FAIL ign_exit2: rd=%b addr=%h want 1/02", bus.pmRdEn, bus.pmAddr); end
  endtask

  // Scenario: 256 NOPs wrap the PC, then HLT at address 0 parks the stage.
  task automatic test_wrap_halt();
    bit ok;
    int bad = 0;
    clear_mem();
    start_prog(ok);
    n_cmp++; if (!ok || bus.pmAddr !== 8'h00) begin n_err++; $display("FAIL wrap_start: ok=%0b addr=%h want 00", ok, bus.pmAddr); end
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 1) mem[0] = 16'hF000;
      tick();
      tick();
      n_cmp++; if (bus.pmRdEn !== 1'b1 || bus.pmAddr !== 8'(i % 256) || bus.halted !== 1'b0) begin
        n_err++; $display("FAIL wrap_fetch: step %0d rd=%b addr=%h h=%b want 1/%h/0", i, bus.pmRdEn, bus.pmAddr, bus.halted, 8'(i % 256));
      end
    end
    tick();
    tick();
    tick();
    n_cmp++; if (bus.halted !== 1'b1 || bus.pmAddr !== 8'h01) begin n_err++; $display("FAIL halt_enter: h=%b addr=%h want 1/01", bus.halted, bus.pmAddr); end
    for (int j = 0; j < 12; j++) begin
      bus.IF = 1'($urandom_range(0, 1));
      bus.aluDone = 1'($urandom_range(0, 1));
      tick();
      if (bus.pmRdEn !== 1'b0 || bus.halted !== 1'b1 || bus.MOVstr !== 1'b0 || bus.ALUstr !== 1'b0) bad++;
    end
    bus.IF = 1'b0;
    bus.aluDone = 1'b0;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL halt_stays: %0d bad cycles want 0", bad); end
  endtask

  // Scenario: random program; model predicts fetch order, launch kind, operands and period.
  task automatic test_random();
    bit ok;
    logic [23:0] e;
    logic [3:0] op;
    bit is_mov, is_alu, is_nop, is_hlt;
    int lat, n;
    clear_mem();
    exp_q.delete();
    n = $urandom_range(30, 45);
    for (int p = 0; p < n; p++) mem[p] = {4'($urandom_range(0, 14)), 12'($urandom)};
    mem[n] = {4'hF, 12'($urandom)};
    for (int p = 0; p <= n; p++) exp_q.push_back({8'(p), mem[p]});
    start_prog(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_start: no fetch got %0b want 1", ok); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      op = e[15:12];
      is_hlt = (op == 4'hF);
      is_nop = (op == 4'h0);
      is_mov = (op == 4'h9) || (op == 4'hA);
      is_alu = !(is_hlt || is_nop || is_mov);
      n_cmp++; if (bus.pmRdEn !== 1'b1 || bus.pmAddr !== e[23:16]) begin n_err++; $display("FAIL rnd_fetch: rd=%b addr=%h want 1/%h", bus.pmRdEn, bus.pmAddr, e[23:16]); end
      bus.IF = 1'($urandom_range(0, 1));
      bus.aluDone = 1'($urandom_range(0, 1));
      tick();
      n_cmp++; if (bus.MOVstr !== 1'b0 || bus.ALUstr !== 1'b0 || bus.pmRdEn !== 1'b0) begin n_err++; $display("FAIL rnd_wait: mov=%b alu=%b rd=%b want 0/0/0", bus.MOVstr, bus.ALUstr, bus.pmRdEn); end
      bus.IF = 1'($urandom_range(0, 1));
      bus.aluDone = 1'($urandom_range(0, 1));
      tick();
      n_cmp++; if (bus.MOVstr !== is_mov || bus.ALUstr !== is_alu) begin n_err++; $display("FAIL rnd_strobe: instr=%h mov=%b alu=%b want %b/%b", e[15:0], bus.MOVstr, bus.ALUstr, is_mov, is_alu); end
      bus.IF = 1'b0;
      bus.aluDone = 1'b0;
      if (is_hlt) begin
        tick();
        n_cmp++; if (bus.halted !== 1'b1 || bus.pmAddr !== 8'(n + 1)) begin n_err++; $display("FAIL rnd_halt: h=%b addr=%h want 1/%h", bus.halted, bus.pmAddr, 8'(n + 1)); end
      end else if (is_nop) begin
        tick();
      end else begin
        lat = $urandom_range(1, 6);
        for (int j = 1; j <= lat; j++) begin
          tick();
          n_cmp++; if ({bus.opCode, bus.opI, bus.opJ} !== e[15:0] || bus.pmRdEn !== 1'b0 || bus.MOVstr !== 1'b0 || bus.ALUstr !== 1'b0) begin
            n_err++; $display("FAIL rnd_exec: cyc %0d ops=%h%h%h rd=%b mov=%b alu=%b want %h/0/0/0", j, bus.opCode, bus.opI, bus.opJ, bus.pmRdEn, bus.MOVstr, bus.ALUstr, e[15:0]);
          end
          if (is_mov) begin
            bus.aluDone = 1'($urandom_range(0, 1));
            bus.IF = (j == lat);
          end else begin
            bus.IF = 1'($urandom_range(0, 1));
            bus.aluDone = (j == lat);
          end
        end
        tick();
        bus.IF = 1'b0;
        bus.aluDone = 1'b0;
      end
    end
  endtask

`ifdef IFD_TIMEOUT_EN
  // Scenario: no done for 32 EXEC cycles faults; a done on cycle 32 wins over the timeout.
  task automatic test_timeout();
    bit ok;
    int bad = 0;
    clear_mem();
    mem[0] = 16'h9A35;
    start_prog(ok);
    n_cmp++; if (!ok || bus.execErr !== 1'b0) begin n_err++; $display("FAIL tmo_start: ok=%0b err=%b want 1/0", ok, bus.execErr); end
    tick();
    tick();
    for (int j = 1; j <= 32; j++) begin
      tick();
      if (bus.execErr !== 1'b0 || bus.pmRdEn !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL tmo_early: %0d bad cycles want 0", bad); end
    tick();
    n_cmp++; if (bus.execErr !== 1'b1 || bus.pmRdEn !== 1'b1 || bus.pmAddr !== 8'h01) begin n_err++; $display("FAIL tmo_fire: err=%b rd=%b addr=%h want 1/1/01", bus.execErr, bus.pmRdEn, bus.pmAddr); end
    tick(); tick(); tick();
    n_cmp++; if (bus.execErr !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: err=%b want 1", bus.execErr); end
    start_prog(ok);
    n_cmp++; if (!ok || bus.execErr !== 1'b0) begin n_err++; $display("FAIL tmo_reset: ok=%0b err=%b want 1/0", ok, bus.execErr); end
    tick();
    tick();
    for (int j = 1; j <= 32; j++) begin
      tick();
      if (j == 32) bus.IF = 1'b1;
    end
    tick();
    bus.IF = 1'b0;
    n_cmp++; if (bus.execErr !== 1'b0 || bus.pmRdEn !== 1'b1 || bus.pmAddr !== 8'h01) begin n_err++; $display("FAIL tmo_done_wins: err=%b rd=%b addr=%h want 0/1/01", bus.execErr, bus.pmRdEn, bus.pmAddr); end
  endtask
`else
  // Scenario: without the watchdog EXEC waits indefinitely and never faults.
  task automatic test_no_timeout();
    bit ok;
    int bad = 0;
    clear_mem();
    mem[0] = 16'h9A35;
    start_prog(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL notmo_start: no fetch got %0b want 1", ok); end
    tick();
    tick();
    for (int j = 0; j < 100; j++) begin
      tick();
      if (bus.execErr !== 1'b0 || bus.pmRdEn !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL notmo_wait: %0d bad cycles want 0", bad); end
    bus.IF = 1'b1;
    tick();
    bus.IF = 1'b0;
    n_cmp++; if (bus.pmRdEn !== 1'b1 || bus.pmAddr !== 8'h01 || bus.execErr !== 1'b0) begin n_err++; $display("FAIL notmo_exit: rd=%b addr=%h err=%b want 1/01/0", bus.pmRdEn, bus.pmAddr, bus.execErr); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    bus.IF = 1'b0;
    bus.aluDone = 1'b0;
    clear_mem();
    test_reset();
    test_mov();
    test_nop_alu();
    test_ignore_done();
    test_wrap_halt();
    test_random();
`ifdef IFD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
